// File: rtl/sine_lut_pkg.sv
// Shared definitions for the two-channel sine LUT scheduler.
// Default widths and the channel-index type.
package sine_lut_pkg;

    localparam int ADDR_BITS_DEF     = 10;
    localparam int DATA_OUT_BITS_DEF = 12;
    localparam int PHASE_BITS_DEF    = 24;
    localparam int NUM_CH            = 2;

    typedef logic ch_idx_t;

endpackage

// File: rtl/dds_phase_acc.sv
// Per-channel phase accumulator with pending request flag.
// Flags a tick that lands on an unserviced request.
module dds_phase_acc
    import sine_lut_pkg::*;
#(
    parameter int ADDR_BITS  = ADDR_BITS_DEF,
    parameter int PHASE_BITS = PHASE_BITS_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  i_enable,
    input  logic                  i_tick,
    input  logic [PHASE_BITS-1:0] i_fcw,
    input  logic                  i_grant,
    output logic [ADDR_BITS-1:0]  o_addr,
    output logic                  o_pending,
    output logic                  o_overrun
);

    logic [PHASE_BITS-1:0] r_acc;
    logic                  r_pending;
    logic                  r_overrun;

    // Advance phase on tick; a grant consumes the request unless a tick re-arms it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_acc     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!i_enable) begin
            r_pending <= 1'b0;
        end else if (i_tick) begin
            r_acc     <= r_acc + i_fcw;
            r_pending <= 1'b1;
            if (r_pending && !i_grant) begin
                r_overrun <= 1'b1;
            end
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end

    assign o_addr    = r_acc[PHASE_BITS-1 -: ADDR_BITS];
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sine_lut_sched.sv
// Two-channel scheduler sharing one synchronous sine LUT.
// Round-robin grant, two-stage read pipeline, per-channel output regs.
module sine_lut_sched
    import sine_lut_pkg::*;
#(
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int DATA_OUT_BITS = DATA_OUT_BITS_DEF,
    parameter int PHASE_BITS    = PHASE_BITS_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     enable_in,
    input  logic                     ch0_tick_in,
    input  logic                     ch1_tick_in,
    input  logic [PHASE_BITS-1:0]    ch0_fcw_in,
    input  logic [PHASE_BITS-1:0]    ch1_fcw_in,
    output logic [ADDR_BITS-1:0]     lut_addr_out,
    input  logic [DATA_OUT_BITS-1:0] lut_data_in,
    output logic [DATA_OUT_BITS-1:0] ch0_sample_out,
    output logic [DATA_OUT_BITS-1:0] ch1_sample_out,
    output logic                     ch0_valid_out,
    output logic                     ch1_valid_out,
    input  logic                     ch0_ready_in,
    input  logic                     ch1_ready_in,
    output logic [1:0]               overrun_out,
    output logic                     busy_out
);

    logic [NUM_CH-1:0]     w_tick;
    logic [NUM_CH-1:0]     w_ready;
    logic [PHASE_BITS-1:0] w_fcw [NUM_CH];
    logic [ADDR_BITS-1:0]  w_addr [NUM_CH];
    logic [NUM_CH-1:0]     w_pending;
    logic [NUM_CH-1:0]     w_tick_ovr;
    logic [NUM_CH-1:0]     w_grant;
    logic                  w_gnt_vld;
    ch_idx_t               w_gnt_ch;

    logic [ADDR_BITS-1:0]     r_addr;
    ch_idx_t                  r_rr;
    logic                     r_s1_vld;
    ch_idx_t                  r_s1_ch;
    logic                     r_s2_vld;
    ch_idx_t                  r_s2_ch;
    logic [DATA_OUT_BITS-1:0] r_sample [NUM_CH];
    logic [NUM_CH-1:0]        r_valid;
    logic [NUM_CH-1:0]        r_cap_ovr;

    assign w_tick  = {ch1_tick_in, ch0_tick_in};
    assign w_ready = {ch1_ready_in, ch0_ready_in};
    assign w_fcw[0] = ch0_fcw_in;
    assign w_fcw[1] = ch1_fcw_in;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        dds_phase_acc #(
            .ADDR_BITS  (ADDR_BITS),
            .PHASE_BITS (PHASE_BITS)
        ) u_acc (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .i_enable  (enable_in),
            .i_tick    (w_tick[gi]),
            .i_fcw     (w_fcw[gi]),
            .i_grant   (w_grant[gi]),
            .o_addr    (w_addr[gi]),
            .o_pending (w_pending[gi]),
            .o_overrun (w_tick_ovr[gi])
        );
    end

    // Round-robin pick among pending channels; pointer breaks ties only.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = 1'b0;
        w_grant   = '0;
        if (enable_in) begin
            unique case (w_pending)
                2'b11: begin
                    w_gnt_vld = 1'b1;
                    w_gnt_ch  = r_rr;
                end
                2'b01: w_gnt_vld = 1'b1;
                2'b10: begin
                    w_gnt_vld = 1'b1;
                    w_gnt_ch  = 1'b1;
                end
                default: ;
            endcase
        end
        if (w_gnt_vld) begin
            w_grant[w_gnt_ch] = 1'b1;
        end
    end

    // Issue the LUT address and track the channel tag through the read latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_addr   <= '0;
            r_rr     <= 1'b0;
            r_s1_vld <= 1'b0;
            r_s1_ch  <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_ch  <= 1'b0;
        end else begin
            r_s1_vld <= w_gnt_vld;
            r_s1_ch  <= w_gnt_ch;
            r_s2_vld <= r_s1_vld;
            r_s2_ch  <= r_s1_ch;
            if (w_gnt_vld) begin
                r_addr <= w_addr[w_gnt_ch];
                r_rr   <= !w_gnt_ch;
            end
        end
    end

    // Capture returning data; a capture wins over a same-edge consume.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_sample[n] <= '0;
            end
            r_valid   <= '0;
            r_cap_ovr <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (r_s2_vld && (r_s2_ch == ch_idx_t'(n))) begin
                    r_sample[n] <= lut_data_in;
                    r_valid[n]  <= 1'b1;
                    if (r_valid[n] && !w_ready[n]) begin
                        r_cap_ovr[n] <= 1'b1;
                    end
                end else if (r_valid[n] && w_ready[n]) begin
                    r_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign lut_addr_out   = r_addr;
    assign ch0_sample_out = r_sample[0];
    assign ch1_sample_out = r_sample[1];
    assign ch0_valid_out  = r_valid[0];
    assign ch1_valid_out  = r_valid[1];
    assign overrun_out    = w_tick_ovr | r_cap_ovr;
    assign busy_out       = (|w_pending) | r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_sine_lut_sched.sv
// Self-checking bench for sine_lut_sched.
// Directed scenarios plus randomized run against a reference model.
module tb_sine_lut_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        t0, t1;
    logic [23:0] f0, f1;
    logic [9:0]  lut_addr;
    logic [11:0] lut_data = '0;
    logic [11:0] s0, s1;
    logic        v0, v1;
    logic        r0, r1;
    logic [1:0]  ovr;
    logic        busy;

    int checks = 0;
    int passed = 0;

    // reference model state
    bit [23:0] m_acc [2];
    bit        m_pend [2];
    int        m_rr;
    bit        m_p1v, m_p2v;
    int        m_p1ch, m_p2ch;
    bit [9:0]  m_p1a, m_p2a;
    bit [9:0]  m_addr;
    bit [11:0] m_sample [2];
    bit        m_valid [2];
    bit        m_ovr [2];

    always #5 clk = ~clk;

    // registered LUT whose content equals its address
    always @(posedge clk) lut_data <= {2'b00, lut_addr};

    sine_lut_sched dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .enable_in      (en),
        .ch0_tick_in    (t0),
        .ch1_tick_in    (t1),
        .ch0_fcw_in     (f0),
        .ch1_fcw_in     (f1),
        .lut_addr_out   (lut_addr),
        .lut_data_in    (lut_data),
        .ch0_sample_out (s0),
        .ch1_sample_out (s1),
        .ch0_valid_out  (v0),
        .ch1_valid_out  (v1),
        .ch0_ready_in   (r0),
        .ch1_ready_in   (r1),
        .overrun_out    (ovr),
        .busy_out       (busy)
    );

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_acc[n] = '0; m_pend[n] = 0; m_sample[n] = '0;
            m_valid[n] = 0; m_ovr[n] = 0;
        end
        m_rr = 0; m_p1v = 0; m_p2v = 0; m_p1ch = 0; m_p2ch = 0;
        m_p1a = '0; m_p2a = '0; m_addr = '0;
    endtask

    // one clock of the spec behaviour, evaluated from pre-edge state
    task automatic model_step(input bit e, input bit [1:0] tk,
                              input bit [23:0] a, input bit [23:0] b,
                              input bit [1:0] rd);
        bit [23:0] fw [2];
        bit gv; int g; bit [9:0] ga;
        fw[0] = a; fw[1] = b;
        gv = 0; g = 0; ga = '0;
        if (e && (m_pend[0] || m_pend[1])) begin
            gv = 1;
            if (m_pend[0] && m_pend[1]) g = m_rr;
            else g = m_pend[0] ? 0 : 1;
            ga = m_acc[g][23:14];
            m_addr = ga;
            m_rr = 1 - g;
        end
        for (int n = 0; n < 2; n++) begin
            if (m_p2v && m_p2ch == n) begin
                if (m_valid[n] && !rd[n]) m_ovr[n] = 1;
                m_sample[n] = {2'b00, m_p2a};
                m_valid[n] = 1;
            end else if (m_valid[n] && rd[n]) begin
                m_valid[n] = 0;
            end
        end
        m_p2v = m_p1v; m_p2ch = m_p1ch; m_p2a = m_p1a;
        m_p1v = gv; m_p1ch = g; m_p1a = ga;
        for (int n = 0; n < 2; n++) begin
            if (!e) begin
                m_pend[n] = 0;
            end else if (tk[n]) begin
                if (m_pend[n] && !(gv && g == n)) m_ovr[n] = 1;
                m_pend[n] = 1;
                m_acc[n] = m_acc[n] + fw[n];
            end else if (gv && g == n) begin
                m_pend[n] = 0;
            end
        end
    endtask

    task automatic do_reset();
        en = 1; t0 = 0; t1 = 0; f0 = '0; f1 = '0; r0 = 1; r1 = 1;
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({lut_addr, s0, s1, v0, v1, ovr, busy} !== '0)
            $display("FAIL reset_outputs: addr=%0d s0=%0d s1=%0d v=%b%b ovr=%b busy=%b, required all 0",
                     lut_addr, s0, s1, v1, v0, ovr, busy);
        else passed++;
    endtask

    task automatic test_single();
        do_reset();
        f0 = 24'h004000; t0 = 1;
        @(negedge clk);
        t0 = 0;
        checks++;
        if (lut_addr !== 10'd0) $display("FAIL single_addr_early: got %0d required 0", lut_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if (lut_addr !== 10'd1) $display("FAIL single_addr: got %0d required 1", lut_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0) $display("FAIL single_valid_early: got %b required 0", v0);
        else passed++;
        @(negedge clk);
        checks++;
        if ({v0, s0} !== {1'b1, 12'd1})
            $display("FAIL single_sample: valid=%b sample=%0d required valid=1 sample=1", v0, s0);
        else passed++;
    endtask

    task automatic test_both();
        do_reset();
        f0 = 24'h004000; f1 = 24'h008000; t0 = 1; t1 = 1;
        @(negedge clk);
        t0 = 0; t1 = 0;
        @(negedge clk);
        checks++;
        if (lut_addr !== 10'd1) $display("FAIL both_addr0: got %0d required 1", lut_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if (lut_addr !== 10'd2) $display("FAIL both_addr1: got %0d required 2", lut_addr);
        else passed++;
        @(negedge clk);
        checks++;
        if ({v0, s0, v1} !== {1'b1, 12'd1, 1'b0})
            $display("FAIL both_cap0: v0=%b s0=%0d v1=%b required 1,1,0", v0, s0, v1);
        else passed++;
        @(negedge clk);
        checks++;
        if ({v1, s1} !== {1'b1, 12'd2})
            $display("FAIL both_cap1: v1=%b s1=%0d required 1,2", v1, s1);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        f0 = 24'h004000; t0 = 1;
        @(negedge clk);
        t0 = 0;
        repeat (4) @(negedge clk);
        f0 = 24'hFFC000; t0 = 1;
        @(negedge clk);
        t0 = 0;
        @(negedge clk);
        checks++;
        if ({lut_addr, ovr} !== {10'd0, 2'b00})
            $display("FAIL wrap_addr: addr=%0d ovr=%b required addr=0 ovr=00", lut_addr, ovr);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if ({v0, s0, ovr} !== {1'b1, 12'd0, 2'b00})
            $display("FAIL wrap_sample: v0=%b s0=%0d ovr=%b required 1,0,00", v0, s0, ovr);
        else passed++;
    endtask

    task automatic test_overrun();
        do_reset();
        f0 = 24'h004000; r0 = 0; t0 = 1;
        repeat (4) @(negedge clk);
        t0 = 0;
        checks++;
        if ({v0, s0, ovr} !== {1'b1, 12'd1, 2'b00})
            $display("FAIL ovr_first: v0=%b s0=%0d ovr=%b required 1,1,00", v0, s0, ovr);
        else passed++;
        @(negedge clk);
        checks++;
        if (ovr !== 2'b01) $display("FAIL ovr_flag: got %b required 01", ovr);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if ({v0, s0, ovr} !== {1'b1, 12'd4, 2'b01})
            $display("FAIL ovr_newest: v0=%b s0=%0d ovr=%b required 1,4,01", v0, s0, ovr);
        else passed++;
        r0 = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({v0, busy, ovr} !== {1'b0, 1'b0, 2'b01})
            $display("FAIL ovr_sticky: v0=%b busy=%b ovr=%b required 0,0,01", v0, busy, ovr);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        f0 = 24'h004000; t0 = 1;
        @(negedge clk);
        t0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({lut_addr, s0, s1, v0, v1, ovr, busy} !== '0)
                $display("FAIL reset_mid_c%0d: addr=%0d s0=%0d v0=%b ovr=%b busy=%b required all 0",
                         i, lut_addr, s0, v0, ovr, busy);
            else passed++;
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        f0 = 24'h004000; f1 = 24'h008000; t0 = 1; t1 = 1;
        @(negedge clk);
        t0 = 0; t1 = 0;
        @(negedge clk);
        en = 0;
        @(negedge clk);
        checks++;
        if ({busy, lut_addr} !== {1'b1, 10'd1})
            $display("FAIL endrop_inflight: busy=%b addr=%0d required 1,1", busy, lut_addr);
        else passed++;
        t1 = 1;
        @(negedge clk);
        checks++;
        if ({v0, s0, busy} !== {1'b1, 12'd1, 1'b0})
            $display("FAIL endrop_drain: v0=%b s0=%0d busy=%b required 1,1,0", v0, s0, busy);
        else passed++;
        repeat (3) @(negedge clk);
        checks++;
        if ({v1, lut_addr, busy} !== {1'b0, 10'd1, 1'b0})
            $display("FAIL endrop_no_ch1: v1=%b addr=%0d busy=%b required 0,1,0", v1, lut_addr, busy);
        else passed++;
        en = 1; t1 = 1;
        @(negedge clk);
        t1 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({v1, s1} !== {1'b1, 12'd4})
            $display("FAIL endrop_acc_held: v1=%b s1=%0d required 1,4", v1, s1);
        else passed++;
    endtask

    task automatic test_random();
        bit [1:0] tk, rd;
        bit e;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            checks++;
            if (lut_addr !== m_addr)
                $display("FAIL rand_addr c%0d: got %0d required %0d", c, lut_addr, m_addr);
            else passed++;
            checks++;
            if ({s1, s0} !== {m_sample[1], m_sample[0]})
                $display("FAIL rand_sample c%0d: got %0d/%0d required %0d/%0d",
                         c, s0, s1, m_sample[0], m_sample[1]);
            else passed++;
            checks++;
            if ({v1, v0} !== {m_valid[1], m_valid[0]})
                $display("FAIL rand_valid c%0d: got %b%b required %b%b",
                         c, v1, v0, m_valid[1], m_valid[0]);
            else passed++;
            checks++;
            if (ovr !== {m_ovr[1], m_ovr[0]})
                $display("FAIL rand_ovr c%0d: got %b required %b%b", c, ovr, m_ovr[1], m_ovr[0]);
            else passed++;
            checks++;
            if (busy !== (m_pend[0] | m_pend[1] | m_p1v | m_p2v))
                $display("FAIL rand_busy c%0d: got %b required %b",
                         c, busy, m_pend[0] | m_pend[1] | m_p1v | m_p2v);
            else passed++;
            e  = ($urandom_range(0, 9) != 0);
            tk = 2'($urandom_range(0, 3));
            rd = {($urandom_range(0, 4) > 1), ($urandom_range(0, 4) > 1)};
            en = e; t0 = tk[0]; t1 = tk[1]; r0 = rd[0]; r1 = rd[1];
            f0 = 24'($urandom); f1 = 24'($urandom);
            @(posedge clk);
            model_step(e, tk, f0, f1, rd);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 0; en = 0; t0 = 0; t1 = 0; f0 = '0; f1 = '0; r0 = 1; r1 = 1;
        test_reset();
        test_single();
        test_both();
        test_wrap();
        test_overrun();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
